// File: rtl/systolic_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  systolic_feeder_pkg : operand element type and array geometry for the feeder
//  Rev 1.0
// ============================================================================
`ifndef SYS_ARRAY_LEN
`define SYS_ARRAY_LEN 4
`endif

package systolic_feeder_pkg;

   localparam int unsigned SYS_N  = `SYS_ARRAY_LEN;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned MAX_K  = 256;
   localparam int unsigned KW     = $clog2(MAX_K + 1);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
   } scalar_t;

   localparam scalar_t SCALAR_ZERO = '0;

   // Data never travels without its valid bit.
   function automatic scalar_t sanitize(input scalar_t s);
      return s.valid ? s : SCALAR_ZERO;
   endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_feeder_skew_line.sv
`default_nettype none
// ============================================================================
//  systolic_feeder_skew_line : DEPTH-stage scalar delay line, async reset to zero
//  Rev 1.0
// ============================================================================
module systolic_feeder_skew_line
   import systolic_feeder_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic    clk,
   input  logic    rst_n,
   input  scalar_t d_i,
   output scalar_t q_o
);

   scalar_t [DEPTH-1:0] pipe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= d_i;
         for (int s = 1; s < int'(DEPTH); s++) begin
            pipe_q[s] <= pipe_q[s-1];
         end
      end
   end

   assign q_o = pipe_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  systolic_feeder : accepts K operand steps per job and drives them onto the
//  array as a diagonal wavefront (lane i delayed i+1 cycles). Rev 1.0
// ============================================================================
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int unsigned N = SYS_N
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [KW-1:0]    k_len,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  scalar_t [N-1:0]  a_vec,
   input  scalar_t [N-1:0]  b_vec,
   output scalar_t [N-1:0]  row_out,
   output scalar_t [N-1:0]  col_out,
   output logic             clear,
   input  logic             array_ready,
   output logic             busy,
   output logic             done
);

   localparam int unsigned PW = $clog2(N + 2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_FEED   = 3'd2,
      S_DRAIN  = 3'd3,
      S_SETTLE = 3'd4,
      S_DONE   = 3'd5
   } state_e;

   state_e          state_q;
   logic [KW-1:0]   k_len_q;
   logic [KW-1:0]   k_len_d;
   logic [KW-1:0]   step_cnt_q;
   logic [PW-1:0]   phase_cnt_q;
   logic            clear_q;
   logic            done_q;
   logic            busy_q;
   logic            accept;

   assign k_len_d   = (k_len > KW'(MAX_K)) ? KW'(MAX_K) : k_len;
   assign vec_ready = (state_q == S_FEED);
   assign accept    = vec_valid && vec_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         k_len_q     <= '0;
         step_cnt_q  <= '0;
         phase_cnt_q <= '0;
         clear_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         clear_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (k_len == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_CLEAR;
                     clear_q <= 1'b1;
                     k_len_q <= k_len_d;
                  end
               end
            end
            S_CLEAR: begin
               state_q    <= S_FEED;
               step_cnt_q <= '0;
            end
            S_FEED: begin
               if (accept) begin
                  step_cnt_q <= step_cnt_q + KW'(1);
                  if (step_cnt_q + KW'(1) == k_len_q) begin
                     state_q     <= S_DRAIN;
                     phase_cnt_q <= '0;
                  end
               end
            end
            S_DRAIN: begin
               // N cycles flush the deepest lane after the final accept.
               if (phase_cnt_q == PW'(N - 1)) begin
                  state_q     <= S_SETTLE;
                  phase_cnt_q <= '0;
               end else begin
                  phase_cnt_q <= phase_cnt_q + PW'(1);
               end
            end
            S_SETTLE: begin
               // N+1 cycles cover the array shift depth plus its ready register.
               if (phase_cnt_q == PW'(N)) begin
                  if (array_ready) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  phase_cnt_q <= phase_cnt_q + PW'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign clear = clear_q;
   assign done  = done_q;
   assign busy  = busy_q;

   for (genvar i = 0; i < int'(N); i++) begin : g_lane
      scalar_t a_in;
      scalar_t b_in;

      assign a_in = accept ? sanitize(a_vec[i]) : SCALAR_ZERO;
      assign b_in = accept ? sanitize(b_vec[i]) : SCALAR_ZERO;

      systolic_feeder_skew_line #(.DEPTH(i + 1)) u_row (
         .clk   (clk),
         .rst_n (rst_n),
         .d_i   (a_in),
         .q_o   (row_out[i])
      );

      systolic_feeder_skew_line #(.DEPTH(i + 1)) u_col (
         .clk   (clk),
         .rst_n (rst_n),
         .d_i   (b_in),
         .q_o   (col_out[i])
      );
   end

endmodule

`default_nettype wire
